// File: rtl/reg_scoreboard_if.sv
// Decode/writeback hazard bus between the pipeline and the scoreboard.
// master = pipeline side, slave = scoreboard.
interface reg_scoreboard_if #(
  parameter int REGWORDS  = 32,
  parameter int REGNOBITS = 5
);
  logic                 valid_DE;
  logic [REGNOBITS-1:0] rs1_DE;
  logic                 rs1_used_DE;
  logic [REGNOBITS-1:0] rs2_DE;
  logic                 rs2_used_DE;
  logic [REGNOBITS-1:0] rd_DE;
  logic                 wr_reg_DE;
  logic                 clear_from_branch_DE;
  logic                 wr_reg_WB;
  logic [REGNOBITS-1:0] wregno_WB;
  logic                 pipeline_stall_DE;
  logic [REGWORDS-1:0]  busy_vec_DE;
  logic                 underflow_err;

  modport master (
    output valid_DE, rs1_DE, rs1_used_DE, rs2_DE, rs2_used_DE,
    output rd_DE, wr_reg_DE, clear_from_branch_DE,
    output wr_reg_WB, wregno_WB,
    input  pipeline_stall_DE, busy_vec_DE, underflow_err
  );

  modport slave (
    input  valid_DE, rs1_DE, rs1_used_DE, rs2_DE, rs2_used_DE,
    input  rd_DE, wr_reg_DE, clear_from_branch_DE,
    input  wr_reg_WB, wregno_WB,
    output pipeline_stall_DE, busy_vec_DE, underflow_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters beside decode.
// Drives the DE stall from RAW and counter-full hazards.
module reg_scoreboard #(
  parameter int REGWORDS  = 32,
  parameter int REGNOBITS = 5,
  parameter int CNTBITS   = 2
) (
  input logic        clk,
  input logic        reset,
  reg_scoreboard_if.slave bus
);

  localparam logic [CNTBITS-1:0] MAX = '1;
  localparam logic [CNTBITS-1:0] ONE = CNTBITS'(1);

  logic [CNTBITS-1:0]  cnt [REGWORDS];
  logic [CNTBITS-1:0]  eff [REGWORDS];
  logic [REGWORDS-1:0] rel;
  logic [REGWORDS-1:0] alloc_hit;
  logic [REGWORDS-1:0] busy;
  logic                src_haz;
  logic                dst_full;
  logic                stall;
  logic                issue;
  logic                alloc;
  logic                uf_hit;
  logic                uf_q;

  // WB release decode; eff bypasses a same-cycle release
  always_comb begin
    for (int r = 0; r < REGWORDS; r++) begin
      rel[r] = bus.wr_reg_WB
            && (bus.wregno_WB == REGNOBITS'(r))
            && (r != 0);
      eff[r] = cnt[r]
             - ((rel[r] && cnt[r] != '0) ? ONE : '0);
      busy[r] = (cnt[r] != '0);
    end
  end

  // stall, issue and allocation decision for the DE instruction
  always_comb begin
    src_haz = (bus.rs1_used_DE && bus.rs1_DE != '0
               && eff[bus.rs1_DE] != '0)
           || (bus.rs2_used_DE && bus.rs2_DE != '0
               && eff[bus.rs2_DE] != '0);
    dst_full = bus.wr_reg_DE && bus.rd_DE != '0
            && eff[bus.rd_DE] == MAX;
    stall = bus.valid_DE && !bus.clear_from_branch_DE
         && (src_haz || dst_full);
    issue = bus.valid_DE && !bus.clear_from_branch_DE
         && !stall;
    alloc = issue && bus.wr_reg_DE && bus.rd_DE != '0;
    for (int r = 0; r < REGWORDS; r++) begin
      alloc_hit[r] = alloc && (bus.rd_DE == REGNOBITS'(r));
    end
    uf_hit = |(rel & ~alloc_hit & ~busy);
  end

  // counter update; alloc and release on one register cancel
  always_ff @(posedge clk) begin
    for (int r = 0; r < REGWORDS; r++) begin
      if (reset || r == 0) begin
        cnt[r] <= '0;
      end else if (alloc_hit[r] && !rel[r]) begin
        cnt[r] <= cnt[r] + ONE;
      end else if (rel[r] && !alloc_hit[r] && busy[r]) begin
        cnt[r] <= cnt[r] - ONE;
      end
    end
  end

  // sticky underflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      uf_q <= 1'b0;
    end else if (uf_hit) begin
      uf_q <= 1'b1;
    end
  end

  assign bus.pipeline_stall_DE = stall;
  assign bus.busy_vec_DE       = busy;
  assign bus.underflow_err     = uf_q;

endmodule
